cardinal_nic: RTL and testbench

- Network interface controller for one Cardinal processor node, on the data-memory side of the core, beside dmem.
- The processor sees it as four memory-mapped 64-bit locations, selected by nicEn plus a 2-bit address:
  - input buffer
  - input status
  - output buffer
  - output status
- The network side uses a ready/send handshake per channel to and from the node's router port.
- One-word buffer per direction; each buffer's full flag serves as the channel status.

---
 rtl/cardinal_nic_if.sv | 30 +++
 rtl/cardinal_nic.sv | 114 +++++++++++
 tb/tb_cardinal_nic.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cardinal_nic_if.sv
// Processor-bus and router-port signal bundle for the Cardinal node NIC.
// Bit 0 is the MSB of every data word.
interface cardinal_nic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [0:DATA_WIDTH-1] d_in;
  logic [0:DATA_WIDTH-1] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;

  // Processor and router side
  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro,
    input  d_out, net_ri, net_so, net_do
  );

  // NIC side
  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro,
    output d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic.sv
// Cardinal node NIC: one-word input and output buffers behind four memory-mapped locations.
// Define NIC_POLARITY_EN to add net_polarity and restrict outbound transfers to even-polarity cycles.
//
// state     | meaning
// IN_EMPTY  | input buffer free, router may send (net_ri = 1)
// IN_FULL   | input buffer holds an unread word
// OUT_EMPTY | output buffer free, processor write accepted
// OUT_FULL  | output buffer holds a word waiting for the router
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic Clock,
  input  logic Reset,
`ifdef NIC_POLARITY_EN
  input  logic net_polarity,
`endif
  cardinal_nic_if.slave nic
);
  localparam logic [ADDR_WIDTH-1:0] A_IN_BUF  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_IN_STS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_BUF = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_STS = ADDR_WIDTH'(3);

  typedef enum logic {IN_EMPTY, IN_FULL}   in_state_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  in_state_t             in_state, in_state_nxt;
  out_state_t            out_state, out_state_nxt;
  logic [0:DATA_WIDTH-1] in_buf, out_buf;
  logic                  in_full, out_full;
  logic                  rd_en, rd_in_buf, wr_out_buf;
  logic                  in_load, out_load, xfer;

  assign in_full    = (in_state == IN_FULL);
  assign out_full   = (out_state == OUT_FULL);
  assign rd_en      = nic.nicEn & ~nic.nicWrEn;
  assign rd_in_buf  = rd_en & (nic.addr == A_IN_BUF);
  assign wr_out_buf = nic.nicEn & nic.nicWrEn & (nic.addr == A_OUT_BUF);

  assign nic.net_ri = ~in_full;
`ifdef NIC_POLARITY_EN
  assign xfer = out_full & nic.net_ro & ~net_polarity;
`else
  assign xfer = out_full & nic.net_ro;
`endif
  assign nic.net_so = xfer;
  assign nic.net_do = out_buf;

  always_comb begin
    in_state_nxt = in_state;
    in_load      = 1'b0;
    unique case (in_state)
      IN_EMPTY: if (nic.net_si) begin
        in_state_nxt = IN_FULL;
        in_load      = 1'b1;
      end
      IN_FULL: if (rd_in_buf) in_state_nxt = IN_EMPTY;
      default: in_state_nxt = IN_EMPTY;
    endcase
  end

  // A write in the transfer cycle refills the buffer with no empty bubble.
  always_comb begin
    out_state_nxt = out_state;
    out_load      = 1'b0;
    unique case (out_state)
      OUT_EMPTY: if (wr_out_buf) begin
        out_state_nxt = OUT_FULL;
        out_load      = 1'b1;
      end
      OUT_FULL: if (xfer) begin
        out_state_nxt = wr_out_buf ? OUT_FULL : OUT_EMPTY;
        out_load      = wr_out_buf;
      end
      default: out_state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      in_state  <= IN_EMPTY;
      out_state <= OUT_EMPTY;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      in_buf  <= '0;
      out_buf <= '0;
    end else begin
      if (in_load)  in_buf  <= nic.net_di;
      if (out_load) out_buf <= nic.d_in;
    end
  end

  // Status reads see the flags as they were before this edge's updates.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      nic.d_out <= '0;
    end else if (rd_en) begin
      unique case (nic.addr)
        A_IN_BUF:  nic.d_out <= in_buf;
        A_IN_STS:  nic.d_out <= {{(DATA_WIDTH-1){1'b0}}, in_full};
        A_OUT_BUF: nic.d_out <= out_buf;
        A_OUT_STS: nic.d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
        default:   nic.d_out <= nic.d_out;
      endcase
    end
  end
endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic; inputs change 1 ns after posedge,
// checks happen after inputs settle and before the next edge.
module tb_cardinal_nic;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
`ifdef NIC_POLARITY_EN
  logic net_polarity = 1'b0;
`endif
  int n_chk  = 0;
  int n_pass = 0;

  cardinal_nic_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) nic ();

  cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
`ifdef NIC_POLARITY_EN
    .net_polarity (net_polarity),
`endif
    .nic          (nic.slave)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    nic.nicEn = 1'b1; nic.nicWrEn = 1'b0; nic.addr = a;
    cyc();
    nic.nicEn = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    nic.nicEn = 1'b1; nic.nicWrEn = 1'b1; nic.addr = a; nic.d_in = d;
    cyc();
    nic.nicEn = 1'b0; nic.nicWrEn = 1'b0;
  endtask

  initial begin
    nic.addr = 2'b00; nic.d_in = '0; nic.nicEn = 1'b0; nic.nicWrEn = 1'b0;
    nic.net_si = 1'b0; nic.net_di = '0; nic.net_ro = 1'b0;

    repeat (3) cyc();
    Reset = 1'b0;
    #1;
    check("rst_net_ri", 64'(nic.net_ri), 64'h1);
    check("rst_net_so", 64'(nic.net_so), 64'h0);
    check("rst_net_do", nic.net_do, 64'h0);
    check("rst_d_out", nic.d_out, 64'h0);
    rd(2'b01); check("rst_in_sts", nic.d_out, 64'h0);
    rd(2'b11); check("rst_out_sts", nic.d_out, 64'h0);

    // inbound word
    nic.net_si = 1'b1; nic.net_di = 64'hDEAD_BEEF_0000_0001;
    cyc();
    nic.net_si = 1'b0;
    check("in_ri_low", 64'(nic.net_ri), 64'h0);
    rd(2'b01); check("in_sts_full", nic.d_out, 64'h1);
    // router violation while full is ignored
    nic.net_si = 1'b1; nic.net_di = 64'h1111_2222_3333_4444;
    cyc();
    nic.net_si = 1'b0;
    rd(2'b00); check("in_data", nic.d_out, 64'hDEAD_BEEF_0000_0001);
    check("in_ri_back", 64'(nic.net_ri), 64'h1);
    rd(2'b01); check("in_sts_empty", nic.d_out, 64'h0);
    repeat (2) cyc();
    check("d_out_hold", nic.d_out, 64'h0);
    rd(2'b00); check("in_stale", nic.d_out, 64'hDEAD_BEEF_0000_0001);
    check("in_stale_ri", 64'(nic.net_ri), 64'h1);

    // outbound with router stalled
    wr(2'b10, 64'h0123_4567_89AB_CDEF);
    rd(2'b11); check("out_sts_full", nic.d_out, 64'h1);
    check("out_so_stall", 64'(nic.net_so), 64'h0);
    wr(2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
    check("out_drop", nic.net_do, 64'h0123_4567_89AB_CDEF);
    rd(2'b10); check("out_rd_buf", nic.d_out, 64'h0123_4567_89AB_CDEF);
    nic.net_ro = 1'b1;
    #1;
    check("out_so", 64'(nic.net_so), 64'h1);
    check("out_do", nic.net_do, 64'h0123_4567_89AB_CDEF);
    cyc();
    check("out_so_done", 64'(nic.net_so), 64'h0);
    rd(2'b11); check("out_sts_empty", nic.d_out, 64'h0);

    // transfer and write in the same cycle
    nic.net_ro = 1'b0;
    wr(2'b10, 64'h5);
    nic.net_ro = 1'b1;
    nic.nicEn = 1'b1; nic.nicWrEn = 1'b1; nic.addr = 2'b10; nic.d_in = 64'h2;
    #1;
    check("sim_so_old", 64'(nic.net_so), 64'h1);
    check("sim_do_old", nic.net_do, 64'h5);
    cyc();
    nic.nicEn = 1'b0; nic.nicWrEn = 1'b0;
    check("sim_do_new", nic.net_do, 64'h2);
    check("sim_so_new", 64'(nic.net_so), 64'h1);
    cyc();
    check("sim_so_drain", 64'(nic.net_so), 64'h0);

    // ignored writes
    nic.net_ro = 1'b0;
    wr(2'b00, 64'hABCD);
    wr(2'b01, 64'h1);
    rd(2'b01); check("wr00_ignored", nic.d_out, 64'h0);
    nic.nicWrEn = 1'b1; nic.addr = 2'b10; nic.d_in = 64'h9;
    cyc();
    nic.nicWrEn = 1'b0;
    rd(2'b11); check("wr_no_en", nic.d_out, 64'h0);

    // reset with both buffers full
    nic.net_si = 1'b1; nic.net_di = 64'h77;
    cyc();
    nic.net_si = 1'b0;
    wr(2'b10, 64'h88);
    check("pre_rst_ri", 64'(nic.net_ri), 64'h0);
    nic.net_ro = 1'b1;
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check("mid_rst_ri", 64'(nic.net_ri), 64'h1);
    check("mid_rst_so", 64'(nic.net_so), 64'h0);
    check("mid_rst_do", nic.net_do, 64'h0);
    rd(2'b01); check("mid_rst_in_sts", nic.d_out, 64'h0);
    rd(2'b11); check("mid_rst_out_sts", nic.d_out, 64'h0);

`ifdef NIC_POLARITY_EN
    nic.net_ro = 1'b0;
    wr(2'b10, 64'h33);
    nic.net_ro = 1'b1; net_polarity = 1'b1;
    #1; check("pol_odd1", 64'(nic.net_so), 64'h0);
    cyc();
    check("pol_odd1_held", 64'(nic.net_so), 64'h0);
    net_polarity = 1'b0;
    #1; check("pol_even", 64'(nic.net_so), 64'h1);
    cyc();
    net_polarity = 1'b1;
    #1; check("pol_odd2", 64'(nic.net_so), 64'h0);
    rd(2'b11); check("pol_sts", nic.d_out, 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
